// File: rtl/mac_recv_filter_if.sv
// Receive byte stream from the deserialiser plus the parsed-header results
// handed on to the ARP/IP/UDP receivers.
interface mac_recv_filter_if #(
  parameter int CNT_W = 16
);
  logic             rx_enable;
  logic [7:0]       data;
  logic             active;
  logic             hdr_valid;
  logic             broadcast;
  logic             multicast;
  logic [2:0]       type_idx;
  logic             vlan_valid;
  logic [11:0]      vlan_id;
  logic [47:0]      remote_mac;
  logic [CNT_W-1:0] drop_count;

  modport master (
    output rx_enable, data,
    input  active, hdr_valid, broadcast, multicast, type_idx,
           vlan_valid, vlan_id, remote_mac, drop_count
  );

  modport slave (
    input  rx_enable, data,
    output active, hdr_valid, broadcast, multicast, type_idx,
           vlan_valid, vlan_id, remote_mac, drop_count
  );
endinterface

// File: rtl/mac_recv_filter.sv
// Ethernet RX header parser/filter: destination check, source capture, optional
// single 802.1Q tag strip and EtherType table match; rejected frames are counted.
module mac_recv_filter #(
  parameter int                    NUM_TYPES = 4,
  parameter logic [16*NUM_TYPES-1:0] TYPE_LIST = {16'h0800, 16'h0806, 16'h86DD, 16'h88CC},
  parameter bit                    VLAN_EN   = 1'b1,
  parameter bit                    MCAST_EN  = 1'b0,
  parameter int                    CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [47:0]      local_mac,
  mac_recv_filter_if.slave rx
);

  typedef enum logic [2:0] {DST, SRC, TYPE, VLAN, PAYLOAD, DISCARD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       byte_no_q, byte_no_d;
  logic             ucast_ok_q, ucast_ok_d;
  logic             bcast_ok_q, bcast_ok_d;
  logic             mcast_ok_q, mcast_ok_d;
  logic             tag_seen_q, tag_seen_d;
  logic [47:0]      temp_mac_q, temp_mac_d;
  logic [7:0]       type_hi_q, type_hi_d;
  logic [11:0]      tci_q, tci_d;

  logic             hdr_valid_q;
  logic             broadcast_q;
  logic             multicast_q;
  logic [2:0]       type_idx_q;
  logic             vlan_valid_q;
  logic [11:0]      vlan_id_q;
  logic [47:0]      remote_mac_q;
  logic [CNT_W-1:0] drop_q;

  logic             latch;
  logic             drop_inc;
  logic [7:0]       mac_byte;
  logic [15:0]      type16;
  logic             type_hit;
  logic [2:0]       type_hit_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    case (byte_no_q)
      3'd5:    mac_byte = local_mac[47:40];
      3'd4:    mac_byte = local_mac[39:32];
      3'd3:    mac_byte = local_mac[31:24];
      3'd2:    mac_byte = local_mac[23:16];
      3'd1:    mac_byte = local_mac[15:8];
      default: mac_byte = local_mac[7:0];
    endcase
  end

  // Scanning from the top index down leaves the lowest matching entry in place.
  always_comb begin
    type16       = {type_hi_q, rx.data};
    type_hit     = 1'b0;
    type_hit_idx = '0;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      if (TYPE_LIST[16*(NUM_TYPES-1-i) +: 16] == type16) begin
        type_hit     = 1'b1;
        type_hit_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_no_d  = byte_no_q;
    ucast_ok_d = ucast_ok_q;
    bcast_ok_d = bcast_ok_q;
    mcast_ok_d = mcast_ok_q;
    tag_seen_d = tag_seen_q;
    temp_mac_d = temp_mac_q;
    type_hi_d  = type_hi_q;
    tci_d      = tci_q;
    latch      = 1'b0;
    drop_inc   = 1'b0;

    if (!rx.rx_enable) begin
      state_d    = DST;
      byte_no_d  = 3'd5;
      ucast_ok_d = 1'b1;
      bcast_ok_d = 1'b1;
      tag_seen_d = 1'b0;
      // A gap that cuts a header short costs one drop; idle, payload and discard gaps do not.
      if ((state_q == SRC) || (state_q == TYPE) || (state_q == VLAN) ||
          ((state_q == DST) && (byte_no_q != 3'd5)))
        drop_inc = 1'b1;
    end else begin
      case (state_q)
        DST: begin
          if (rx.data != mac_byte) ucast_ok_d = 1'b0;
          if (rx.data != 8'hFF)    bcast_ok_d = 1'b0;
          if (byte_no_q == 3'd5)   mcast_ok_d = rx.data[0];
          if (byte_no_q == 3'd0) begin
            state_d   = SRC;
            byte_no_d = 3'd5;
          end else begin
            byte_no_d = byte_no_q - 3'd1;
          end
        end
        SRC: begin
          temp_mac_d = {temp_mac_q[39:0], rx.data};
          if (byte_no_q == 3'd0) begin
            if (bcast_ok_q || ucast_ok_q || (MCAST_EN && mcast_ok_q)) begin
              state_d   = TYPE;
              byte_no_d = 3'd1;
            end else begin
              state_d  = DISCARD;
              drop_inc = 1'b1;
            end
          end else begin
            byte_no_d = byte_no_q - 3'd1;
          end
        end
        TYPE: begin
          if (byte_no_q == 3'd1) begin
            type_hi_d = rx.data;
            byte_no_d = 3'd0;
          end else if (VLAN_EN && (type16 == 16'h8100) && !tag_seen_q) begin
            state_d   = VLAN;
            byte_no_d = 3'd1;
          end else if (type_hit) begin
            state_d = PAYLOAD;
            latch   = 1'b1;
          end else begin
            state_d  = DISCARD;
            drop_inc = 1'b1;
          end
        end
        VLAN: begin
          if (byte_no_q == 3'd1) begin
            tci_d[11:8] = rx.data[3:0];
            byte_no_d   = 3'd0;
          end else begin
            tci_d[7:0] = rx.data;
            tag_seen_d = 1'b1;
            state_d    = TYPE;
            byte_no_d  = 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DST;
      byte_no_q    <= 3'd5;
      ucast_ok_q   <= 1'b1;
      bcast_ok_q   <= 1'b1;
      mcast_ok_q   <= 1'b0;
      tag_seen_q   <= 1'b0;
      temp_mac_q   <= '0;
      type_hi_q    <= '0;
      tci_q        <= '0;
      hdr_valid_q  <= 1'b0;
      broadcast_q  <= 1'b0;
      multicast_q  <= 1'b0;
      type_idx_q   <= '0;
      vlan_valid_q <= 1'b0;
      vlan_id_q    <= '0;
      remote_mac_q <= '0;
      drop_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_no_q   <= byte_no_d;
      ucast_ok_q  <= ucast_ok_d;
      bcast_ok_q  <= bcast_ok_d;
      mcast_ok_q  <= mcast_ok_d;
      tag_seen_q  <= tag_seen_d;
      temp_mac_q  <= temp_mac_d;
      type_hi_q   <= type_hi_d;
      tci_q       <= tci_d;
      hdr_valid_q <= latch;
      // Header results only move on acceptance, so rejected frames leave them intact.
      if (latch) begin
        remote_mac_q <= temp_mac_q;
        type_idx_q   <= type_hit_idx;
        broadcast_q  <= bcast_ok_q;
        multicast_q  <= mcast_ok_q & ~bcast_ok_q;
        vlan_valid_q <= tag_seen_q;
        vlan_id_q    <= tag_seen_q ? tci_q : 12'h000;
      end
      if (drop_inc) drop_q <= sat_inc(drop_q);
    end
  end

  assign rx.active     = rx.rx_enable & (state_q == PAYLOAD);
  assign rx.hdr_valid  = hdr_valid_q;
  assign rx.broadcast  = broadcast_q;
  assign rx.multicast  = multicast_q;
  assign rx.type_idx   = type_idx_q;
  assign rx.vlan_valid = vlan_valid_q;
  assign rx.vlan_id    = vlan_id_q;
  assign rx.remote_mac = remote_mac_q;
  assign rx.drop_count = drop_q;

endmodule

// File: tb/tb_mac_recv_filter.sv
// Randomised frame-level bench for mac_recv_filter: a default instance and a
// VLAN-off / multicast-on / 3-bit-counter instance share one byte stream.
module tb_mac_recv_filter;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx_en   = 1'b0;
  logic [7:0] rx_data = 8'h00;

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  mac_recv_filter_if #(.CNT_W(16)) if1 ();
  mac_recv_filter_if #(.CNT_W(3))  if2 ();
  assign if1.rx_enable = rx_en;
  assign if1.data      = rx_data;
  assign if2.rx_enable = rx_en;
  assign if2.data      = rx_data;

  mac_recv_filter #(.CNT_W(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .local_mac(LOCAL), .rx(if1)
  );
  mac_recv_filter #(
    .NUM_TYPES(3), .TYPE_LIST(48'h8100_0800_0800), .VLAN_EN(1'b0),
    .MCAST_EN(1'b1), .CNT_W(3)
  ) dut2 (
    .clock(clock), .reset_n(reset_n), .local_mac(LOCAL), .rx(if2)
  );

  typedef struct {
    logic        active, hv, bc, mc, vv;
    logic [2:0]  idx;
    logic [11:0] vid;
    logic [47:0] rmac;
    logic [15:0] drop;
  } exp_t;

  typedef struct {
    bit          accept;
    int          decide;
    logic [47:0] src;
    logic [2:0]  idx;
    bit          bc, mc, tg;
    logic [11:0] vid;
  } res_t;

  exp_t        e [2];
  logic [15:0] types [2][8];
  int          ntypes [2];
  bit          vlan_en [2];
  bit          mc_en [2];
  logic [15:0] cnt_max [2];

  logic [7:0]  frm [0:39];
  int          frm_len;
  int          cur_c;
  int          first_act;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_exp();
    for (int d = 0; d < 2; d++) begin
      e[d].active = 0; e[d].hv = 0; e[d].bc = 0; e[d].mc = 0; e[d].vv = 0;
      e[d].idx = 0; e[d].vid = 0; e[d].rmac = 0; e[d].drop = 0;
    end
  endtask

  always @(negedge clock) begin
    if (if1.active && first_act < 0) first_act = cur_c;
    chk("d1.active",     64'(if1.active),     64'(e[0].active));
    chk("d1.hdr_valid",  64'(if1.hdr_valid),  64'(e[0].hv));
    chk("d1.broadcast",  64'(if1.broadcast),  64'(e[0].bc));
    chk("d1.multicast",  64'(if1.multicast),  64'(e[0].mc));
    chk("d1.type_idx",   64'(if1.type_idx),   64'(e[0].idx));
    chk("d1.vlan_valid", 64'(if1.vlan_valid), 64'(e[0].vv));
    chk("d1.vlan_id",    64'(if1.vlan_id),    64'(e[0].vid));
    chk("d1.remote_mac", 64'(if1.remote_mac), 64'(e[0].rmac));
    chk("d1.drop_count", 64'(if1.drop_count), 64'(e[0].drop));
    chk("d2.active",     64'(if2.active),     64'(e[1].active));
    chk("d2.hdr_valid",  64'(if2.hdr_valid),  64'(e[1].hv));
    chk("d2.broadcast",  64'(if2.broadcast),  64'(e[1].bc));
    chk("d2.multicast",  64'(if2.multicast),  64'(e[1].mc));
    chk("d2.type_idx",   64'(if2.type_idx),   64'(e[1].idx));
    chk("d2.vlan_valid", 64'(if2.vlan_valid), 64'(e[1].vv));
    chk("d2.vlan_id",    64'(if2.vlan_id),    64'(e[1].vid));
    chk("d2.remote_mac", 64'(if2.remote_mac), 64'(e[1].rmac));
    chk("d2.drop_count", 64'(if2.drop_count), 64'(e[1].drop));
  end

  task automatic put(input logic [7:0] b);
    frm[frm_len] = b;
    frm_len++;
  endtask

  task automatic put16(input logic [15:0] v);
    put(v[15:8]);
    put(v[7:0]);
  endtask

  task automatic put48(input logic [47:0] v);
    for (int i = 5; i >= 0; i--) put(v[8*i +: 8]);
  endtask

  task automatic put_rand(input int n);
    for (int i = 0; i < n; i++) put(8'($urandom));
  endtask

  // Whole-frame verdict: how many bytes until the decision and what gets latched.
  function automatic res_t classify(input int d);
    res_t        r;
    logic [47:0] dst;
    logic [15:0] t;
    int          pos;
    dst = 0; r.src = 0;
    for (int i = 0; i < 6; i++) begin
      dst   = {dst[39:0], frm[i]};
      r.src = {r.src[39:0], frm[6+i]};
    end
    r.bc = (dst == 48'hFFFF_FFFF_FFFF);
    r.mc = dst[40] && !r.bc;
    r.tg = 0; r.vid = 0; r.idx = 0; r.accept = 0;
    if (!(r.bc || dst == LOCAL || (mc_en[d] && dst[40]))) begin
      r.decide = 12;
      return r;
    end
    t   = {frm[12], frm[13]};
    pos = 14;
    if (vlan_en[d] && t == 16'h8100) begin
      r.tg  = 1;
      r.vid = {frm[14][3:0], frm[15]};
      t     = {frm[16], frm[17]};
      pos   = 18;
    end
    r.decide = pos;
    for (int i = 0; i < ntypes[d]; i++) begin
      if (types[d][i] == t) begin
        r.accept = 1;
        r.idx    = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  task automatic drive_frame(input int L, input int G, input int rst_at);
    res_t r [2];
    bit   decided;
    for (int d = 0; d < 2; d++) r[d] = classify(d);
    first_act = -1;
    for (int c = 0; c < L + G; c++) begin
      @(posedge clock); #1;
      cur_c = c;
      if (c == rst_at) begin
        reset_n = 1'b0;
        clear_exp();
        #1;
        chk("rst.active",     64'(if1.active),     64'd0);
        chk("rst.hdr_valid",  64'(if1.hdr_valid),  64'd0);
        chk("rst.remote_mac", 64'(if1.remote_mac), 64'd0);
        chk("rst.type_idx",   64'(if1.type_idx),   64'd0);
        chk("rst.drop_count", 64'(if1.drop_count), 64'd0);
        chk("rst.d2_drop",    64'(if2.drop_count), 64'd0);
        rx_en = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        return;
      end
      rx_en   = (c < L);
      rx_data = (c < L) ? frm[c] : 8'($urandom);
      for (int d = 0; d < 2; d++) begin
        decided     = (L >= r[d].decide);
        e[d].active = decided && r[d].accept && c >= r[d].decide && c < L;
        e[d].hv     = decided && r[d].accept && c == r[d].decide;
        if (decided && r[d].accept && c == r[d].decide) begin
          e[d].rmac = r[d].src;
          e[d].idx  = r[d].idx;
          e[d].bc   = r[d].bc;
          e[d].mc   = r[d].mc;
          e[d].vv   = r[d].tg;
          e[d].vid  = r[d].vid;
        end
        if ((decided && !r[d].accept && c == r[d].decide) || (!decided && c == L + 1))
          e[d].drop = (e[d].drop == cnt_max[d]) ? cnt_max[d] : e[d].drop + 16'd1;
      end
    end
  endtask

  function automatic logic [15:0] pick_type();
    case ($urandom_range(0, 6))
      0: return 16'h0800;
      1: return 16'h0806;
      2: return 16'h86DD;
      3: return 16'h88CC;
      4: return 16'h8100;
      5: return 16'h9000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic gen_random(output int L);
    logic [47:0] dst;
    frm_len = 0;
    dst = {16'($urandom), 32'($urandom)};
    case ($urandom_range(0, 5))
      0: dst = LOCAL;
      1: dst = 48'hFFFF_FFFF_FFFF;
      2: dst[40] = 1'b0;
      3: dst[40] = 1'b1;
      4: dst = LOCAL ^ (48'h1 << $urandom_range(0, 39));
      default: dst = 48'hFFFF_FFFF_FFFF ^ (48'h1 << $urandom_range(0, 47));
    endcase
    put48(dst);
    put48({16'($urandom), 32'($urandom)});
    if ($urandom_range(0, 2) == 0) begin
      put16(16'h8100);
      put16(16'($urandom));
    end
    put16(pick_type());
    put_rand($urandom_range(0, 5));
    L = ($urandom_range(0, 5) == 0) ? $urandom_range(1, frm_len - 1) : frm_len;
  endtask

  initial begin
    int L;
    types[0][0] = 16'h0800; types[0][1] = 16'h0806; types[0][2] = 16'h86DD; types[0][3] = 16'h88CC;
    types[1][0] = 16'h8100; types[1][1] = 16'h0800; types[1][2] = 16'h0800;
    ntypes[0] = 4;  ntypes[1] = 3;
    vlan_en[0] = 1; vlan_en[1] = 0;
    mc_en[0] = 0;   mc_en[1] = 1;
    cnt_max[0] = 16'hFFFF; cnt_max[1] = 16'h0007;
    clear_exp();
    cur_c = 0;
    first_act = -1;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Unicast, EtherType 0800
    frm_len = 0; put48(LOCAL); put48(48'hA0B1_C2D3_E4F5); put16(16'h0800); put_rand(4);
    drive_frame(frm_len, 2, -1);
    chk("t1.first_active", 64'(first_act),      64'd14);
    chk("t1.remote_mac",   64'(if1.remote_mac), 64'hA0B1_C2D3_E4F5);
    chk("t1.type_idx",     64'(if1.type_idx),   64'd0);
    chk("t1.d2_type_idx",  64'(if2.type_idx),   64'd1);

    // Broadcast, EtherType 0806
    frm_len = 0; put48(48'hFFFF_FFFF_FFFF); put48(48'h5A5A_0102_0304); put16(16'h0806); put_rand(3);
    drive_frame(frm_len, 2, -1);
    chk("t2.broadcast",  64'(if1.broadcast),  64'd1);
    chk("t2.type_idx",   64'(if1.type_idx),   64'd1);
    chk("t2.vlan_valid", 64'(if1.vlan_valid), 64'd0);
    chk("t2.d2_drop",    64'(if2.drop_count), 64'd1);

    // Tagged: TCI 6123, inner 0800
    frm_len = 0; put48(LOCAL); put48(48'h1122_3344_5566); put16(16'h8100); put16(16'h6123);
    put16(16'h0800); put_rand(2);
    drive_frame(frm_len, 2, -1);
    chk("t3.first_active", 64'(first_act),      64'd18);
    chk("t3.vlan_valid",   64'(if1.vlan_valid), 64'd1);
    chk("t3.vlan_id",      64'(if1.vlan_id),    64'h123);
    chk("t3.type_idx",     64'(if1.type_idx),   64'd0);

    // Rejections: wrong unicast, unknown type, multicast
    frm_len = 0; put48(48'h0200_0000_0002); put48(48'h7777_7777_7777); put16(16'h0800); put_rand(2);
    drive_frame(frm_len, 2, -1);
    frm_len = 0; put48(LOCAL); put48(48'h8888_8888_8888); put16(16'h9000); put_rand(2);
    drive_frame(frm_len, 2, -1);
    frm_len = 0; put48(48'h0100_5E00_0001); put48(48'h9999_9999_9999); put16(16'h0800); put_rand(2);
    drive_frame(frm_len, 2, -1);
    chk("t4.drop_count",   64'(if1.drop_count), 64'd3);
    chk("t4.remote_mac",   64'(if1.remote_mac), 64'h1122_3344_5566);
    chk("t4.d2_remote",    64'(if2.remote_mac), 64'h9999_9999_9999);
    chk("t4.d2_multicast", 64'(if2.multicast),  64'd1);

    // Truncated after 9 bytes, then a good frame, then reset mid-payload
    frm_len = 0; put48(LOCAL); put48(48'h1234_5678_9ABC); put16(16'h0800);
    drive_frame(9, 2, -1);
    chk("t5.drop_count", 64'(if1.drop_count), 64'd4);
    frm_len = 0; put48(LOCAL); put48(48'h0A0B_0C0D_0E0F); put16(16'h0800); put_rand(3);
    drive_frame(frm_len, 2, -1);
    chk("t5.remote_mac", 64'(if1.remote_mac), 64'h0A0B_0C0D_0E0F);
    frm_len = 0; put48(LOCAL); put48(48'hCAFE_0000_BEEF); put16(16'h0800); put_rand(5);
    drive_frame(frm_len, 2, 16);

    for (int n = 0; n < 300; n++) begin
      gen_random(L);
      drive_frame(L, $urandom_range(2, 4), -1);
    end
    chk("t6.d2_saturated", 64'(if2.drop_count), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
